// File: rtl/fifo_pkg.sv
// Shared helpers for the single-clock FIFO family: depth from address width
// and the coarse two-bit fill level.
package fifo_pkg;

    function automatic int unsigned depth_of(input int unsigned aw);
        return 32'd1 << aw;
    endfunction

    // Top two count bits, forced to 2'b11 once the FIFO is completely full.
    function automatic logic [1:0] level_of(input int unsigned cnt_v, input int unsigned aw);
        if (cnt_v >= depth_of(aw)) return 2'b11;
        return 2'(cnt_v >> (aw - 1));
    endfunction

endpackage

// File: rtl/generic_dpram_sc.sv
// DW x 2**AW register file: one synchronous write port, one asynchronous read port.
module generic_dpram_sc
    import fifo_pkg::*;
#(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] din,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] dout
);

    localparam int unsigned DEPTH = depth_of(AW);

    logic [DW-1:0] mem [DEPTH];

    // NOTE: storage has no reset; occupancy is tracked by the pointers, so
    // stale contents are never observed and the array maps onto plain flops/LUT RAM.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= din;
    end

    assign dout = mem[raddr];

endmodule

// File: rtl/generic_fifo_sc_prog.sv
// Parametrised single-clock FIFO with standard/FWFT read mode, occupancy count,
// programmable almost-full/almost-empty thresholds and sticky error flags.
module generic_fifo_sc_prog
    import fifo_pkg::*;
#(
    parameter int DW   = 8,
    parameter int AW   = 4,
    parameter int FWFT = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic [DW-1:0] din,
    input  logic          we,
    input  logic          re,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic          almost_empty,
    input  logic [AW:0]   af_thresh,
    input  logic [AW:0]   ae_thresh,
    output logic [AW:0]   cnt,
    output logic [1:0]    level,
    output logic          ovf,
    output logic          udf
);

    localparam int unsigned DEPTH    = depth_of(AW);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [AW-1:0] wp, rp;
    logic [AW:0]   cnt_q;
    logic          ovf_q, udf_q;
    logic          wr_ok, rd_ok;
    logic [DW-1:0] rd_data;

    assign full  = (cnt_q == FULL_CNT);
    assign empty = (cnt_q == '0);

    // A read frees a slot on the same edge, so a full FIFO still takes we&re.
    assign rd_ok = re & ~empty;
    assign wr_ok = we & (~full | rd_ok);

    generic_dpram_sc #(.DW(DW), .AW(AW)) u_ram (
        .clk   (clk),
        .we    (wr_ok & ~clr),
        .waddr (wp),
        .din   (din),
        .raddr (rp),
        .dout  (rd_data)
    );

    // NOTE: all state uses non-blocking assignments so every register samples
    // the pre-edge values of its neighbours regardless of block ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp    <= '0;
            rp    <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else if (clr) begin
            wp    <= '0;
            rp    <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if (wr_ok) wp <= wp + 1'b1;
            if (rd_ok) rp <= rp + 1'b1;
            cnt_q <= cnt_q + {{AW{1'b0}}, wr_ok} - {{AW{1'b0}}, rd_ok};
            if (we & ~wr_ok) ovf_q <= 1'b1;
            if (re & empty)  udf_q <= 1'b1;
        end
    end

    assign cnt          = cnt_q;
    assign ovf          = ovf_q;
    assign udf          = udf_q;
    assign level        = level_of(32'(cnt_q), AW);
    assign almost_full  = (af_thresh != '0) && (cnt_q >= af_thresh);
    assign almost_empty = (cnt_q <= ae_thresh);

    generate
        if (FWFT != 0) begin : g_fwft
            assign dout = empty ? '0 : rd_data;
        end else begin : g_std
            logic [DW-1:0] dout_q;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst)       dout_q <= '0;
                else if (clr)   dout_q <= '0;
                else if (rd_ok) dout_q <= rd_data;
            end
            assign dout = dout_q;
        end
    endgenerate

endmodule

// File: tb/tb_generic_fifo_sc_prog.sv
// Scoreboard bench: a standard-mode and an FWFT instance share stimulus and are
// compared against a queue-based reference model.
module tb_generic_fifo_sc_prog;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          clr = 1'b0;
    logic          we  = 1'b0;
    logic          re  = 1'b0;
    logic [DW-1:0] din = '0;
    logic [AW:0]   af_th = 5'd12;
    logic [AW:0]   ae_th = 5'd3;

    logic [DW-1:0] dout_s, dout_f;
    logic          full_s, full_f, empty_s, empty_f;
    logic          af_s, af_f, ae_s, ae_f;
    logic [AW:0]   cnt_s, cnt_f;
    logic [1:0]    lvl_s, lvl_f;
    logic          ovf_s, ovf_f, udf_s, udf_f;

    generic_fifo_sc_prog #(.DW(DW), .AW(AW), .FWFT(0)) dut_std (
        .clk(clk), .rst(rst), .clr(clr), .din(din), .we(we), .re(re),
        .dout(dout_s), .full(full_s), .empty(empty_s),
        .almost_full(af_s), .almost_empty(ae_s),
        .af_thresh(af_th), .ae_thresh(ae_th),
        .cnt(cnt_s), .level(lvl_s), .ovf(ovf_s), .udf(udf_s)
    );

    generic_fifo_sc_prog #(.DW(DW), .AW(AW), .FWFT(1)) dut_fwft (
        .clk(clk), .rst(rst), .clr(clr), .din(din), .we(we), .re(re),
        .dout(dout_f), .full(full_f), .empty(empty_f),
        .almost_full(af_f), .almost_empty(ae_f),
        .af_thresh(af_th), .ae_thresh(ae_th),
        .cnt(cnt_f), .level(lvl_f), .ovf(ovf_f), .udf(udf_f)
    );

    always #5 clk = ~clk;

    // Reference model: FIFO contents as a queue plus the two sticky flags.
    logic [DW-1:0] model_q[$];
    bit            m_ovf, m_udf;
    logic [DW-1:0] exp_s[$];
    logic [DW-1:0] exp_f[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic check_dut(input string t, input logic [AW:0] c, input logic f, input logic e,
                             input logic af, input logic ae, input logic [1:0] lv,
                             input logic ov, input logic ud);
        int n;
        n = model_q.size();
        check({t, "_cnt"},   c,  n);
        check({t, "_full"},  f,  n == DEPTH);
        check({t, "_empty"}, e,  n == 0);
        check({t, "_af"},    af, (af_th != 0) && (n >= int'(af_th)));
        check({t, "_ae"},    ae, n <= int'(ae_th));
        check({t, "_level"}, lv, (n == DEPTH) ? 3 : n / 8);
        check({t, "_ovf"},   ov, m_ovf);
        check({t, "_udf"},   ud, m_udf);
    endtask

    task automatic check_flags();
        check_dut("std",  cnt_s, full_s, empty_s, af_s, ae_s, lvl_s, ovf_s, udf_s);
        check_dut("fwft", cnt_f, full_f, empty_f, af_f, ae_f, lvl_f, ovf_f, udf_f);
        if (model_q.size() == 0) check("fwft_dout_when_empty", dout_f, 0);
    endtask

    task automatic model_reset();
        model_q.delete();
        exp_s.delete();
        exp_f.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
    endtask

    task automatic model_edge();
        int  n;
        bit  rd, wr;
        if (clr) begin
            model_reset();
            return;
        end
        n  = model_q.size();
        rd = re && (n > 0);
        wr = we && ((n < DEPTH) || rd);
        if (rd) void'(model_q.pop_front());
        if (wr) begin
            model_q.push_back(din);
            exp_s.push_back(din);
            exp_f.push_back(din);
        end
        if (we && !wr) m_ovf = 1'b1;
        if (re && n == 0) m_udf = 1'b1;
    endtask

    // Inputs change at posedge+1; flags are checked at negedge; model steps at posedge.
    task automatic cycle(input bit w, input bit r, input bit c, input logic [DW-1:0] d);
        we = w; re = r; clr = c; din = d;
        @(negedge clk);
        check_flags();
        @(posedge clk);
        model_edge();
        #1;
        we = 1'b0; re = 1'b0; clr = 1'b0;
    endtask

    // Standard-mode monitor: a pop seen at an edge is compared once dout has settled.
    bit fire_s = 1'b0;
    always @(posedge clk) fire_s <= rst && re && !empty_s && !clr;

    always @(negedge clk) begin
        if (fire_s && rst) begin
            if (exp_s.size() == 0) begin
                n_checks++;
                $display("FAIL std_read: pop with empty scoreboard, dout=0x%0h", dout_s);
            end else begin
                check("std_read", dout_s, exp_s.pop_front());
            end
        end
    end

    // FWFT monitor: the head is presented before the acknowledging edge.
    always @(negedge clk) begin
        if (rst && !clr && re && !empty_f) begin
            if (exp_f.size() == 0) begin
                n_checks++;
                $display("FAIL fwft_read: pop with empty scoreboard, dout=0x%0h", dout_f);
            end else begin
                check("fwft_read", dout_f, exp_f.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int writes;
        bit w, r;

        // 1: reset values, fill to full, overflow, ordered readback
        #12;
        check_flags();
        check("std_dout_reset", dout_s, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < DEPTH; i++) cycle(1, 0, 0, 8'(i));
        cycle(1, 0, 0, 8'hEE);
        cycle(0, 0, 0, 0);
        check("full_after_fill", full_s, 1);
        for (int i = 0; i < DEPTH; i++) cycle(0, 1, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 1, 0);
        cycle(0, 0, 0, 0);
        check("std_dout_after_clr", dout_s, 0);

        // 2: random traffic across several pointer wraps
        writes = 0;
        while (writes < 40) begin
            w = (model_q.size() < DEPTH) && ($urandom_range(0, 1) == 1);
            r = (model_q.size() > 0) && ($urandom_range(0, 1) == 1);
            cycle(w, r, 0, 8'($urandom));
            if (w) writes++;
            repeat ($urandom_range(0, 2)) cycle(0, 0, 0, 0);
        end
        while (model_q.size() > 0) cycle(0, 1, 0, 0);
        cycle(0, 0, 0, 0);

        // threshold sweep, including af_thresh == 0 and the extremes
        for (int k = 0; k < 4; k++) begin
            af_th = (k == 0) ? 5'd0 : (k == 1) ? 5'd16 : 5'($urandom_range(1, 16));
            ae_th = (k == 1) ? 5'd0 : 5'($urandom_range(0, 16));
            for (int i = 0; i < DEPTH; i++) cycle(1, 0, 0, 8'($urandom));
            for (int i = 0; i < DEPTH; i++) cycle(0, 1, 0, 0);
            cycle(0, 0, 0, 0);
        end
        af_th = 5'd12;
        ae_th = 5'd3;

        // 3: FWFT head visible right after the write edge, gone after the pop
        cycle(1, 0, 0, 8'hA5);
        #1;
        check("fwft_head_a5", dout_f, 8'hA5);
        check("fwft_not_empty", empty_f, 0);
        cycle(0, 1, 0, 0);
        #1;
        check("fwft_empty_after_pop", empty_f, 1);
        check("fwft_dout_zero", dout_f, 0);

        // 4: we&re when full, then we&re when empty
        for (int i = 0; i < DEPTH; i++) cycle(1, 0, 0, 8'(8'h40 + i));
        cycle(1, 1, 0, 8'h77);
        #1;
        check("cnt_full_wr_rd", cnt_s, DEPTH);
        for (int i = 0; i < DEPTH; i++) cycle(0, 1, 0, 0);
        cycle(1, 1, 0, 8'h55);
        #1;
        check("udf_empty_wr_rd", udf_s, 1);
        check("cnt_empty_wr_rd", cnt_s, 1);
        cycle(0, 1, 0, 0);
        cycle(0, 0, 0, 0);

        // 5: clr beats simultaneous we/re and clears error flags
        for (int i = 0; i < DEPTH; i++) cycle(1, 0, 0, 8'($urandom));
        cycle(1, 0, 0, 8'hDD);
        for (int i = 0; i < 7; i++) cycle(0, 1, 0, 0);
        cycle(0, 0, 0, 0);
        check("cnt_before_clr", cnt_s, 9);
        cycle(1, 1, 1, 8'hCC);
        #1;
        check("cnt_after_clr", cnt_s, 0);
        check("ovf_after_clr", ovf_s, 0);
        cycle(1, 0, 0, 8'h3C);
        cycle(0, 1, 0, 0);
        cycle(0, 0, 0, 0);

        // 6: asynchronous reset mid-burst
        for (int i = 0; i < 7; i++) cycle(1, 0, 0, 8'($urandom));
        cycle(0, 0, 0, 0);
        check("cnt_before_rst", cnt_s, 7);
        #1;
        rst = 1'b0;
        model_reset();
        #1;
        check_flags();
        check("std_dout_async_rst", dout_s, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        cycle(1, 0, 0, 8'h5A);
        cycle(0, 1, 0, 0);
        cycle(0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
